// File: rtl/trn_csr_master.sv
// Wishbone classic-cycle to CSR-bus initiator: each Wishbone cycle becomes one
// CSR write or read. Ack and read data return two cycles after the strobe is sampled.
`timescale 1ns/1ps
module trn_csr_master #(
    parameter int unsigned wb_adr_lsb = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic [13:0] csr_a,
    output logic        csr_we,
    output logic [31:0] csr_do,
    input  logic [31:0] csr_di
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_ACK     = 2'd3;

    logic [1:0]  state_q,  state_d;
    logic [13:0] csr_a_q,  csr_a_d;
    logic [31:0] csr_do_q, csr_do_d;
    logic [31:0] dat_q,    dat_d;
    logic        csr_we_q, csr_we_d;
    logic        ack_q,    ack_d;
    logic        we_q,     we_d;
    logic        abort_q,  abort_d;
    logic        dropped_wr_q, dropped_wr_d;
    logic        unused_s;

    // Address bits outside the CSR window are intentionally ignored.
    assign unused_s = ^{wb_adr_i, dropped_wr_q};

    // Next-state and datapath for one access per Wishbone cycle.
    always_comb begin
        state_d      = state_q;
        csr_a_d      = csr_a_q;
        csr_do_d     = csr_do_q;
        dat_d        = dat_q;
        csr_we_d     = 1'b0;
        ack_d        = 1'b0;
        we_d         = we_q;
        abort_d      = abort_q;
        dropped_wr_d = dropped_wr_q;
        case (state_q)
            S_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    csr_a_d      = wb_adr_i[wb_adr_lsb +: 14];
                    csr_do_d     = wb_dat_i;
                    csr_we_d     = wb_we_i && (wb_sel_i == 4'hF);
                    dropped_wr_d = dropped_wr_q | (wb_we_i && (wb_sel_i != 4'hF));
                    we_d         = wb_we_i;
                    abort_d      = 1'b0;
                    state_d      = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                abort_d = abort_q | ~wb_cyc_i;
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (!we_q) begin
                    dat_d = csr_di;
                end else begin
                    dat_d = dat_q;
                end
                // A cycle dropped in this very cycle must also suppress the ack.
                abort_d = abort_q | ~wb_cyc_i;
                ack_d   = ~(abort_q | ~wb_cyc_i);
                state_d = S_ACK;
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= S_IDLE;
            csr_a_q      <= 14'd0;
            csr_do_q     <= 32'd0;
            dat_q        <= 32'd0;
            csr_we_q     <= 1'b0;
            ack_q        <= 1'b0;
            we_q         <= 1'b0;
            abort_q      <= 1'b0;
            dropped_wr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            csr_a_q      <= csr_a_d;
            csr_do_q     <= csr_do_d;
            dat_q        <= dat_d;
            csr_we_q     <= csr_we_d;
            ack_q        <= ack_d;
            we_q         <= we_d;
            abort_q      <= abort_d;
            dropped_wr_q <= dropped_wr_d;
        end
    end

    assign wb_dat_o = dat_q;
    assign wb_ack_o = ack_q;
    assign csr_a    = csr_a_q;
    assign csr_we   = csr_we_q;
    assign csr_do   = csr_do_q;

endmodule

// File: tb/tb_trn_csr_master.sv
// Bench for trn_csr_master: a small CSR slave stub plus a register-map model
// predicting read data, write pulses and ack timing.
`timescale 1ns/1ps
module tb_trn_csr_master;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [31:0] wb_adr_i = 32'd0;
    logic [31:0] wb_dat_i = 32'd0;
    logic [3:0]  wb_sel_i = 4'd0;
    logic        wb_we_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic [13:0] csr_a;
    logic        csr_we;
    logic [31:0] csr_do;
    logic [31:0] csr_di = 32'd0;

    int checks = 0;
    int errors = 0;

    trn_csr_master dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .csr_a(csr_a), .csr_we(csr_we), .csr_do(csr_do), .csr_di(csr_di)
    );

    always #5 sys_clk = ~sys_clk;

    // Edge counter: at a falling edge it equals the number of rising edges so far.
    int cyc_n = 0;
    always @(posedge sys_clk) cyc_n <= cyc_n + 1;

    // CSR slave stub (block 0): reg 0 = CFG_COMMAND 0x0507 read-only, reg 1 = TRN_FC_SEL
    // (3 bits), regs 2..15 plain scratch. Read data is registered one cycle.
    logic [31:0] stub_mem [16];
    logic [2:0]  trn_fc_sel = 3'd0;
    always @(posedge sys_clk) begin
        if (csr_we && csr_a[13:4] == 10'd0) begin
            if (csr_a[3:0] == 4'd1) trn_fc_sel <= csr_do[2:0];
            else if (csr_a[3:0] != 4'd0) stub_mem[csr_a[3:0]] <= csr_do;
        end
        if (csr_a[13:4] != 10'd0) csr_di <= 32'd0;
        else if (csr_a[3:0] == 4'd0) csr_di <= 32'h0000_0507;
        else if (csr_a[3:0] == 4'd1) csr_di <= {29'd0, trn_fc_sel};
        else csr_di <= stub_mem[csr_a[3:0]];
    end

    // Observation of write pulses and acks.
    int          we_pulses = 0;
    int          ack_total = 0;
    int          last_pulse_cyc = 0;
    logic [13:0] last_a = 14'd0;
    logic [31:0] last_do = 32'd0;
    logic        we_prev = 1'b0;
    logic        we_long = 1'b0;
    always @(negedge sys_clk) begin
        if (csr_we) begin
            we_pulses = we_pulses + 1;
            last_pulse_cyc = cyc_n;
            last_a = csr_a;
            last_do = csr_do;
            if (we_prev) we_long = 1'b1;
        end
        we_prev = csr_we;
        if (wb_ack_o) ack_total = ack_total + 1;
    end

    // Reference model of the register map behind the bridge.
    logic [31:0] m [16];

    function automatic logic [31:0] model_rd(input logic [3:0] blk, input logic [9:0] idx);
        if (blk != 4'd0 || idx >= 10'd16) return 32'd0;
        if (idx == 10'd0) return 32'h0000_0507;
        if (idx == 10'd1) return {29'd0, m[1][2:0]};
        return m[idx[3:0]];
    endfunction

    function automatic void model_wr(input logic [3:0] blk, input logic [9:0] idx, input logic [31:0] d);
        if (blk == 4'd0 && idx < 10'd16 && idx != 10'd0) m[idx[3:0]] = d;
    endfunction

    function automatic logic [31:0] mk_adr(input logic [3:0] blk, input logic [9:0] idx);
        logic [31:0] r;
        r = $urandom;
        return {r[31:16], blk, idx, r[1:0]};
    endfunction

    // Drives one Wishbone cycle, releasing it on ack (or after the budget) and
    // returns ack latency (-1 if none), data at ack and counts seen.
    task automatic wb_single(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                             input logic we, output int ack_lat, output logic [31:0] rdat,
                             output int npulse, output int pulse_lat, output int nack);
        int n, p0, a0;
        @(negedge sys_clk);
        wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel; wb_we_i = we;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        n = cyc_n + 1; p0 = we_pulses; a0 = ack_total;
        ack_lat = -1; rdat = 32'd0;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            if (wb_ack_o && ack_lat < 0) begin
                ack_lat = cyc_n - n;
                rdat = wb_dat_o;
                wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
            end
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        npulse = we_pulses - p0;
        pulse_lat = last_pulse_cyc - n;
        nack = ack_total - a0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge sys_clk);
        checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b want 0", wb_ack_o); end
        checks++; if (wb_dat_o !== 32'd0) begin errors++; $display("FAIL rst_dat: got %h want 0", wb_dat_o); end
        checks++; if (csr_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", csr_we); end
        checks++; if (csr_a !== 14'd0) begin errors++; $display("FAIL rst_a: got %h want 0", csr_a); end
        checks++; if (csr_do !== 32'd0) begin errors++; $display("FAIL rst_do: got %h want 0", csr_do); end
        sys_rst_n = 1'b1;
    endtask

    task automatic test_read();
        int lat, np, pl, na; logic [31:0] rd;
        wb_single(mk_adr(4'd0, 10'd0), 32'hDEAD_BEEF, 4'hF, 1'b0, lat, rd, np, pl, na);
        checks++; if (lat !== 2) begin errors++; $display("FAIL read_lat: got %0d want 2", lat); end
        checks++; if (rd !== 32'h0000_0507) begin errors++; $display("FAIL read_dat: got %h want 00000507", rd); end
        checks++; if (np !== 0) begin errors++; $display("FAIL read_we: got %0d pulses want 0", np); end
        checks++; if (na !== 1) begin errors++; $display("FAIL read_nack: got %0d want 1", na); end
    endtask

    task automatic test_write_readback();
        int lat, np, pl, na; logic [31:0] rd;
        wb_single(mk_adr(4'd0, 10'd1), 32'h0000_0005, 4'hF, 1'b1, lat, rd, np, pl, na);
        model_wr(4'd0, 10'd1, 32'h5);
        checks++; if (np !== 1) begin errors++; $display("FAIL wr_pulses: got %0d want 1", np); end
        checks++; if (pl !== 0) begin errors++; $display("FAIL wr_pulse_cyc: got %0d want 0", pl); end
        checks++; if (last_do !== 32'd5) begin errors++; $display("FAIL wr_do: got %h want 5", last_do); end
        checks++; if (last_a !== 14'd1) begin errors++; $display("FAIL wr_a: got %h want 1", last_a); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL wr_lat: got %0d want 2", lat); end
        wb_single(mk_adr(4'd0, 10'd1), 32'd0, 4'hF, 1'b0, lat, rd, np, pl, na);
        checks++; if (rd !== 32'h5) begin errors++; $display("FAIL wr_readback: got %h want 5", rd); end
        checks++; if (trn_fc_sel !== 3'b101) begin errors++; $display("FAIL wr_fc_sel: got %b want 101", trn_fc_sel); end
    endtask

    task automatic test_partial_write();
        int lat, np, pl, na; logic [31:0] rd;
        wb_single(mk_adr(4'd0, 10'd1), 32'h0000_0007, 4'h1, 1'b1, lat, rd, np, pl, na);
        checks++; if (np !== 0) begin errors++; $display("FAIL part_pulses: got %0d want 0", np); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL part_lat: got %0d want 2", lat); end
        wb_single(mk_adr(4'd0, 10'd1), 32'd0, 4'hF, 1'b0, lat, rd, np, pl, na);
        checks++; if (rd !== model_rd(4'd0, 10'd1)) begin errors++; $display("FAIL part_readback: got %h want %h", rd, model_rd(4'd0, 10'd1)); end
    endtask

    task automatic test_abort();
        int n, p0, a0, lat, np, pl, na; logic [31:0] rd;
        @(negedge sys_clk);
        wb_adr_i = mk_adr(4'd0, 10'd1); wb_dat_i = 32'h3; wb_sel_i = 4'hF; wb_we_i = 1'b1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        n = cyc_n + 1; p0 = we_pulses; a0 = ack_total;
        @(negedge sys_clk);
        @(negedge sys_clk);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        model_wr(4'd0, 10'd1, 32'h3);
        @(negedge sys_clk);
        checks++; if (we_pulses - p0 !== 1) begin errors++; $display("FAIL abort_pulses: got %0d want 1", we_pulses - p0); end
        checks++; if (last_pulse_cyc - n !== 0) begin errors++; $display("FAIL abort_pulse_cyc: got %0d want 0", last_pulse_cyc - n); end
        // Next strobe is presented so that it is sampled two cycles after the CAPTURE edge.
        wb_single(mk_adr(4'd0, 10'd1), 32'd0, 4'hF, 1'b0, lat, rd, np, pl, na);
        checks++; if (ack_total - a0 !== 1) begin errors++; $display("FAIL abort_acks: got %0d want 1", ack_total - a0); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL abort_relat: got %0d want 2", lat); end
        checks++; if (rd !== 32'h3) begin errors++; $display("FAIL abort_readback: got %h want 3", rd); end
    endtask

    task automatic test_reset_mid();
        int lat, np, pl, na; logic [31:0] rd;
        @(negedge sys_clk);
        wb_adr_i = mk_adr(4'd0, 10'd2); wb_dat_i = ~m[2]; wb_sel_i = 4'hF; wb_we_i = 1'b1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        @(negedge sys_clk);
        checks++; if (csr_we !== 1'b1) begin errors++; $display("FAIL mid_we_pre: got %b want 1", csr_we); end
        #1 sys_rst_n = 1'b0;
        #1;
        checks++; if (csr_we !== 1'b0) begin errors++; $display("FAIL mid_we: got %b want 0", csr_we); end
        checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL mid_ack: got %b want 0", wb_ack_o); end
        checks++; if (csr_a !== 14'd0) begin errors++; $display("FAIL mid_a: got %h want 0", csr_a); end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        wb_single(mk_adr(4'd0, 10'd0), 32'd0, 4'hF, 1'b0, lat, rd, np, pl, na);
        checks++; if (lat !== 2) begin errors++; $display("FAIL mid_read_lat: got %0d want 2", lat); end
        checks++; if (rd !== 32'h0000_0507) begin errors++; $display("FAIL mid_read_dat: got %h want 00000507", rd); end
        wb_single(mk_adr(4'd0, 10'd2), 32'd0, 4'hF, 1'b0, lat, rd, np, pl, na);
        checks++; if (rd !== m[2]) begin errors++; $display("FAIL mid_nowrite: got %h want %h", rd, m[2]); end
    endtask

    task automatic test_back_to_back();
        logic [9:0]  idx [3];
        logic [31:0] exp_d [3];
        int n, a0, k;
        idx[0] = 10'd0; idx[1] = 10'd1; idx[2] = 10'($urandom_range(2, 15));
        for (int i = 0; i < 3; i++) exp_d[i] = model_rd(4'd0, idx[i]);
        @(negedge sys_clk);
        wb_adr_i = mk_adr(4'd0, idx[0]); wb_we_i = 1'b0; wb_sel_i = 4'hF;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        n = cyc_n + 1; a0 = ack_total; k = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            if (wb_ack_o && k < 3) begin
                checks++; if (cyc_n - n !== 2 + 4 * k) begin errors++; $display("FAIL b2b_lat%0d: got %0d want %0d", k, cyc_n - n, 2 + 4 * k); end
                checks++; if (wb_dat_o !== exp_d[k]) begin errors++; $display("FAIL b2b_dat%0d: got %h want %h", k, wb_dat_o, exp_d[k]); end
                k++;
                if (k < 3) wb_adr_i = mk_adr(4'd0, idx[k]);
                else begin wb_cyc_i = 1'b0; wb_stb_i = 1'b0; end
            end
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        checks++; if (ack_total - a0 !== 3) begin errors++; $display("FAIL b2b_acks: got %0d want 3", ack_total - a0); end
    endtask

    task automatic test_random();
        int lat, np, pl, na; logic [31:0] rd, d, prev, ad;
        logic [3:0] blk, sel; logic [9:0] idx; logic we, full;
        wb_single(mk_adr(4'd0, 10'd0), 32'd0, 4'hF, 1'b0, lat, rd, np, pl, na);
        prev = 32'h0000_0507;
        for (int it = 0; it < 40; it++) begin
            blk = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            idx = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(16, 1023)) : 10'($urandom_range(0, 15));
            we = 1'($urandom);
            sel = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
            full = (sel == 4'hF);
            d = $urandom;
            ad = mk_adr(blk, idx);
            wb_single(ad, d, sel, we, lat, rd, np, pl, na);
            checks++; if (lat !== 2 || na !== 1) begin errors++; $display("FAIL rnd_ack it%0d: lat %0d acks %0d want 2/1", it, lat, na); end
            if (we) begin
                checks++; if (np !== (full ? 1 : 0)) begin errors++; $display("FAIL rnd_pulses it%0d: got %0d want %0d", it, np, full ? 1 : 0); end
                if (full) begin
                    model_wr(blk, idx, d);
                    checks++; if (last_a !== {blk, idx} || last_do !== d || pl !== 0) begin errors++; $display("FAIL rnd_wr it%0d: a %h do %h cyc %0d want %h %h 0", it, last_a, last_do, pl, {blk, idx}, d); end
                end
                checks++; if (rd !== prev) begin errors++; $display("FAIL rnd_wr_dat it%0d: got %h want %h", it, rd, prev); end
            end else begin
                checks++; if (np !== 0 || rd !== model_rd(blk, idx)) begin errors++; $display("FAIL rnd_rd it%0d: pulses %0d dat %h want 0 %h", it, np, rd, model_rd(blk, idx)); end
                prev = model_rd(blk, idx);
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            stub_mem[i] = $urandom;
            m[i] = stub_mem[i];
        end
        m[1] = 32'd0;
        test_reset();
        test_read();
        test_write_readback();
        test_partial_write();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_random();
        checks++; if (we_long !== 1'b0) begin errors++; $display("FAIL we_width: csr_we high for 2+ cycles"); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
